// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and lane-mask helpers for mem_access_unit
package mem_access_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_e;
  function automatic logic [7:0] size_mask(size_e sz);
    return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0f : 8'hff;
  endfunction
  function automatic logic misaligned(logic [2:0] off, size_e sz);
    logic [3:0] align;
    align = (4'd1 << sz) - 4'd1;
    return |(off & align[2:0]);
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/response handshake plus data-memory port of mem_access_unit
interface mem_access_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_rd, mem_wr, mem_dir, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_rd, mem_wr, mem_dir, mem_wdata
  );
endinterface

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: combinational load lane extract/extend and store byte merge
module byte_lane_unit import mem_access_pkg::*; (
  input  logic [63:0] word_i,
  input  logic [2:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] merged_o
);
  logic [63:0] lane;
  logic [63:0] bit_mask;
  logic [7:0]  byte_mask;
  assign lane      = word_i >> {off_i, 3'b000};
  assign byte_mask = size_mask(size_i) << off_i;
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign bit_mask[8*i +: 8] = {8{byte_mask[i]}};
  end
  assign load_o = size_i == SZ_B ? {{56{signed_i & lane[7]}}, lane[7:0]} :
                  size_i == SZ_H ? {{48{signed_i & lane[15]}}, lane[15:0]} :
                  size_i == SZ_W ? {{32{signed_i & lane[31]}}, lane[31:0]} : lane;
  assign merged_o = (word_i & ~bit_mask) | ((wdata_i << {off_i, 3'b000}) & bit_mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with read-modify-write for sub-doubleword stores
module mem_access_unit import mem_access_pkg::*; #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic        clk,
  input logic        rst_n,
  mem_access_if.slave bus
);
  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [2:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [DATA_W-1:0] load_data, merge_data;
  size_e             req_size;
  assign req_size = size_e'(bus.req_size);
  byte_lane_unit u_lane (
    .word_i  (bus.mem_rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .signed_i(sgn_q),
    .wdata_i (wdata_q),
    .load_o  (load_data),
    .merged_o(merge_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      size_q   <= SZ_B;
      sgn_q    <= 1'b0;
      off_q    <= 3'd0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      dir_q    <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        size_d  = req_size;
        sgn_d   = bus.req_signed;
        off_d   = bus.req_addr[2:0];
        wdata_d = bus.req_wdata;
        dir_d   = {3'b000, bus.req_addr[ADDR_W-1:3]};
        if (misaligned(bus.req_addr[2:0], req_size)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!bus.req_write) begin
          state_d = READ;
        end else if (req_size == SZ_D) begin
          merged_d = bus.req_wdata;
          state_d  = WRITE;
        end else begin
          state_d = RMW_READ;
        end
      end
      READ: begin
        rdata_d = load_data;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RMW_READ: begin
        merged_d = merge_data;
        state_d  = WRITE;
      end
      WRITE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign bus.mem_rd    = state_q != WRITE;
  assign bus.mem_wr    = state_q == WRITE;
  assign bus.mem_dir   = dir_q;
  assign bus.mem_wdata = merged_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a 16-doubleword memory
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] mem [16];
  mem_access_if #(.ADDR_W(64), .DATA_W(64)) bus ();
  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_dir[3:0]];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_dir[3:0]] <= bus.mem_wdata;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [63:0] a, input logic [63:0] wd, input int lat,
                     input logic [63:0] exp_rd, input logic exp_err);
    int k;
    logic wr_seen, clash;
    @(negedge clk);
    check({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 1; wr_seen = 1'b0; clash = 1'b0;
    while (!bus.rsp_valid && k < 8) begin
      wr_seen |= bus.mem_wr;
      clash |= bus.mem_rd == bus.mem_wr;
      @(negedge clk);
      k++;
    end
    wr_seen |= bus.mem_wr;
    clash |= bus.mem_rd == bus.mem_wr;
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " rdata"}, bus.rsp_rdata, exp_rd);
    check({tag, " error"}, 64'(bus.rsp_error), 64'(exp_err));
    check({tag, " mem_wr"}, 64'(wr_seen), 64'(w & ~exp_err));
    check({tag, " rd_wr_excl"}, 64'(clash), 64'd0);
    check({tag, " resp_ready"}, 64'(bus.req_ready), 64'd0);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst ready", 64'(bus.req_ready), 64'd1);
    check("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst rdata", bus.rsp_rdata, 64'd0);
    check("rst error", 64'(bus.rsp_error), 64'd0);
    check("rst mem_rd", 64'(bus.mem_rd), 64'd1);
    check("rst mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst mem_dir", bus.mem_dir, 64'd0);
    check("rst mem_wdata", bus.mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle mem_wr", 64'(bus.mem_wr), 64'd0);
    txn("st_d", 1, 2'b11, 0, 64'h10, 64'h1122334455667788, 2, 64'd0, 0);
    check("st_d mem", mem[2], 64'h1122334455667788);
    check("st_d dir", bus.mem_dir, 64'd2);
    txn("ld_d", 0, 2'b11, 0, 64'h10, 64'd0, 2, 64'h1122334455667788, 0);
    txn("st_b", 1, 2'b00, 0, 64'h13, 64'h00000000000000AB, 3, 64'd0, 0);
    check("st_b mem", mem[2], 64'h11223344AB667788);
    check("st_b wdata", bus.mem_wdata, 64'h11223344AB667788);
    txn("ld_bs", 0, 2'b00, 1, 64'h13, 64'd0, 2, 64'hFFFFFFFFFFFFFFAB, 0);
    txn("ld_hu", 0, 2'b01, 0, 64'h16, 64'd0, 2, 64'h0000000000001122, 0);
    txn("st_d2", 1, 2'b11, 0, 64'h10, 64'h8000000000000000, 2, 64'd0, 0);
    txn("ld_ws", 0, 2'b10, 1, 64'h14, 64'd0, 2, 64'hFFFFFFFF80000000, 0);
    txn("ld_wu", 0, 2'b10, 0, 64'h14, 64'd0, 2, 64'h0000000080000000, 0);
    txn("ld_hs", 0, 2'b01, 1, 64'h16, 64'd0, 2, 64'hFFFFFFFFFFFF8000, 0);
    txn("st_d0", 1, 2'b11, 0, 64'h20, 64'd0, 2, 64'd0, 0);
    check("st_d0 dir", bus.mem_dir, 64'd4);
    txn("mis_h", 0, 2'b01, 0, 64'h11, 64'd0, 1, 64'd0, 1);
    check("mis_h dir", bus.mem_dir, 64'd2);
    check("mis_h mem_rd", 64'(bus.mem_rd), 64'd1);
    txn("mis_w", 1, 2'b10, 0, 64'h1A, 64'hDEADBEEF, 1, 64'd0, 1);
    check("mis_w dir", bus.mem_dir, 64'd3);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_signed = 1'b0; bus.req_addr = 64'h22; bus.req_wdata = 64'hBEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort rmw mem_wr", 64'(bus.mem_wr), 64'd0);
    @(negedge clk);
    check("abort write mem_wr", 64'(bus.mem_wr), 64'd1);
    check("abort write wdata", bus.mem_wdata, 64'h00000000BEEF0000);
    #1 rst_n = 1'b0;
    #1;
    check("abort mem_wr drop", 64'(bus.mem_wr), 64'd0);
    check("abort rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort ready", 64'(bus.req_ready), 64'd1);
    check("abort dir", bus.mem_dir, 64'd0);
    @(negedge clk);
    check("abort rst mem_wr", 64'(bus.mem_wr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort no rsp", 64'(bus.rsp_valid), 64'd0);
    check("abort mem kept", mem[4], 64'd0);
    txn("post_ld", 0, 2'b11, 0, 64'h10, 64'd0, 2, 64'h8000000000000000, 0);
    check("post_ld dir", bus.mem_dir, 64'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the execute stage and the data memory. Accepts one byte/half/word/doubleword access per request, converts the byte address into the memory's doubleword index, and performs read-modify-write for sub-doubleword stores. Returns zero- or sign-extended load data to writeback and stalls the core through a ready/valid handshake.

## Interface
- `ADDR_W`, 64: request byte-address width.
- `DATA_W`, 64: data width; fixed at 64.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit accepts a request this cycle.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 doubleword.
- `req_signed`  in  1: sign-extend load result (ignored for stores and doublewords).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  64: store data, right-aligned.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_rdata`  out  64: extended load data; 0 for stores and errors.
- `rsp_error`  out  1: misaligned access; valid with `rsp_valid`.
- `mem_rd`  out  1: memory read enable.
- `mem_wr`  out  1: memory write enable.
- `mem_dir`  out  64: doubleword index = {3'b0, addr[63:3]}.
- `mem_wdata`  out  64: merged write data.
- `mem_rdata`  in  64: combinational read data of `mem_dir`.

## Operation
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch size, signed, write, offset = addr[2:0], wdata; load `mem_dir`.
  - Misaligned (offset not a multiple of 2^size) -> RESP with error; no memory access.
  - Load -> READ. Doubleword store -> WRITE (merged = wdata). Sub-doubleword store -> RMW_READ.
- READ: capture `mem_rdata` at edge, extract lane at offset*8, zero/sign-extend per size/signed -> RESP.
- RMW_READ: capture `mem_rdata` with bytes [offset, offset+2^size) replaced by low bytes of wdata (little-endian) -> WRITE.
- WRITE: `mem_wr`=1, `mem_wdata`=merged word -> RESP.
- RESP: `rsp_valid`=1, `req_ready`=0 -> IDLE.
- `mem_rd`=1 in every state except WRITE; `mem_wr`=1 only in WRITE; never both high, never both low.
- `mem_dir` changes only on request acceptance in IDLE and holds for the whole transaction and afterwards.
- `rsp_rdata`/`rsp_error` hold their value until the next RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `mem_rd`=1, `mem_wr`=0, `mem_dir`=0, `mem_wdata`=0.
- Accept at edge N. `rsp_valid` in cycle: load N+2, doubleword store N+2, sub-word store N+3, misaligned N+1.
- Requests are accepted only in IDLE; `req_valid` outside IDLE is ignored, and the requester holds it.
- No back-to-back acceptance: IDLE is at least one cycle between transactions.
- Reset assertion mid-transaction aborts immediately: `mem_wr` drops asynchronously, no response is produced, latched request is discarded.
- Offset arithmetic is 3-bit; lane shift = offset<<3, always within 64 bits once alignment has been checked.

## Structure
- Package `mem_access_pkg`: size encodings (SZ_B, SZ_H, SZ_W, SZ_D), state enum, function size-to-bytemask.
- Sub-module `byte_lane_unit` (combinational): load extract/extend and store merge from (word, offset, size, signed, wdata). The FSM, latches and memory drive remain in `mem_access_unit`.

## Test plan
- Reset: check all outputs at reset values; `mem_wr` never pulses during reset or in IDLE.
- Doubleword store 0x1122334455667788 to addr 0x10, then doubleword load addr 0x10 -> `mem_dir`=2, rdata 0x1122334455667788, responses at N+2.
- Byte store 0xAB to addr 0x13 over word 0x1122334455667788 -> written word 0x11223344AB667788, response at N+3.
- Signed word load addr 0x14 of word 0x80000000_00000000 (upper word 0x80000000) -> 0xFFFFFFFF80000000; unsigned -> 0x0000000080000000.
- Half load addr 0x11 -> `rsp_error`=1 at N+1, rdata 0, no `mem_wr`, `mem_dir` updated with `mem_rd` high.
- Async reset asserted during WRITE of sub-word store -> `mem_wr` low immediately, no `rsp_valid`, next request handled normally.
